instr_responder: RTL and testbench

Memory-side responder for the instruction fetch interface: it serves the `instr_req`/`instr_adr` → `instr_valid`/`instr_read` handshake that the instruction cache issues on a miss. It is backed by a word-addressed on-chip instruction memory with a configurable number of wait states. A separate load port fills the memory before and during execution. It sits between the instruction cache and the program memory in the processor example.

---
 rtl/instr_responder_pkg.sv | 17 +
 rtl/instr_ram.sv | 30 +++
 rtl/instr_responder.sv | 103 ++++++++++
 tb/tb_instr_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_responder_pkg.sv
// Shared definitions for the instruction-fetch responder.
//   resp_state_e : responder FSM encodings (2-bit)
//   DATA_W       : fetched word width
//   CNT_W        : wait-state counter width
package instr_responder_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        RESP_STATE_IDLE    = 2'd0,
        RESP_STATE_WAIT    = 2'd1,
        RESP_STATE_RESPOND = 2'd2,
        RESP_STATE_DONE    = 2'd3
    } resp_state_e;

endpackage

// File: rtl/instr_ram.sv
// Word-addressed 2^ADDR_BITS x 32 synchronous instruction RAM.
//   clk              : clock
//   we, wadr, wdata  : load write port
//   re, radr         : read-enable-gated read port
//   rdata            : registered read data (read-first vs. same-cycle write)
// Contents are never reset.
module instr_ram
    import instr_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wadr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] radr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // Read and write in the same process: a same-edge write to the read
    // word lands after the old value has been captured.
    always_ff @(posedge clk) begin
        if (we) mem[wadr] <= wdata;
        if (re) rdata <= mem[radr];
    end

endmodule

// File: rtl/instr_responder.sv
// Memory-side responder for the instruction-cache fetch handshake.
//   clk, res            : clock, async active-low reset
//   instr_req/instr_adr : fetch request, byte address held until instr_valid
//   instr_valid         : one-cycle response strobe
//   instr_read          : fetched word (0 unless instr_valid)
//   instr_err           : out-of-range flag, pulses with instr_valid
//   load_we/adr/data    : memory load port, usable in any state
module instr_responder
    import instr_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 instr_req,
    input  logic [31:0]          instr_adr,
    output logic                 instr_valid,
    output logic [DATA_W-1:0]    instr_read,
    output logic                 instr_err,
    input  logic                 load_we,
    input  logic [ADDR_BITS-1:0] load_adr,
    input  logic [DATA_W-1:0]    load_data
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    resp_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [ADDR_BITS-1:0] adr_q;
    logic                 in_range_q;
    logic                 ram_re;
    logic [DATA_W-1:0]    ram_q;

    instr_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .we    (load_we),
        .wadr  (load_adr),
        .wdata (load_data),
        .re    (ram_re),
        .radr  (adr_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) state_q <= RESP_STATE_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ram_re  = 1'b0;
        case (state_q)
            RESP_STATE_IDLE:
                if (instr_req) state_d = RESP_STATE_WAIT;
            RESP_STATE_WAIT:
                // A dropped request aborts in any wait cycle, including the last.
                if (!instr_req) begin
                    state_d = RESP_STATE_IDLE;
                end else if (cnt_q == '0) begin
                    ram_re  = 1'b1;
                    state_d = RESP_STATE_RESPOND;
                end
            RESP_STATE_RESPOND:
                state_d = RESP_STATE_DONE;
            RESP_STATE_DONE:
                if (!instr_req) state_d = RESP_STATE_IDLE;
            default:
                state_d = RESP_STATE_IDLE;
        endcase
    end

    // Address/range latch and wait counter. The counter saturates at 0,
    // so a full 255 load counts down without wrapping.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q      <= '0;
            adr_q      <= '0;
            in_range_q <= 1'b0;
        end else if (state_q == RESP_STATE_IDLE && instr_req) begin
            cnt_q      <= WAIT_LD;
            adr_q      <= instr_adr[ADDR_BITS+1:2];
            in_range_q <= (instr_adr[31:ADDR_BITS+2] == '0);
        end else if (state_q == RESP_STATE_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // RAM data is valid during RESPOND; registering it here keeps every
    // output free of combinational input paths.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            instr_valid <= 1'b0;
            instr_read  <= '0;
            instr_err   <= 1'b0;
        end else begin
            instr_valid <= (state_q == RESP_STATE_RESPOND);
            instr_read  <= (state_q == RESP_STATE_RESPOND && in_range_q) ? ram_q : '0;
            instr_err   <= (state_q == RESP_STATE_RESPOND && !in_range_q);
        end
    end

endmodule

// File: tb/tb_instr_responder.sv
module tb_instr_responder;
    import instr_responder_pkg::*;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] adr_a = '0, adr_b = '0;
    logic        load_we = 1'b0;
    logic [9:0]  load_adr = '0;
    logic [31:0] load_data = '0;
    logic        valid_a, err_a, valid_b, err_b;
    logic [31:0] read_a, read_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // a: default wait states; b: zero wait states
    instr_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .res(res), .instr_req(req_a), .instr_adr(adr_a),
        .instr_valid(valid_a), .instr_read(read_a), .instr_err(err_a),
        .load_we(load_we), .load_adr(load_adr), .load_data(load_data));

    instr_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .res(res), .instr_req(req_b), .instr_adr(adr_b),
        .instr_valid(valid_b), .instr_read(read_b), .instr_err(err_b),
        .load_we(load_we), .load_adr(load_adr), .load_data(load_data));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        load_we = 1'b1; load_adr = a; load_data = d;
        step();
        load_we = 1'b0;
    endtask

    // Raise req, sample edge E0, then watch 10 more edges with req held.
    // Reports edge of first valid (-1 if none), pulse count, data and err.
    task automatic run_req(input bit sel_b, input logic [31:0] adr,
                           output int lat, output int pulses,
                           output logic [31:0] data, output logic err);
        lat = -1; pulses = 0; data = '0; err = 1'b0;
        if (sel_b) begin req_b = 1'b1; adr_b = adr; end
        else       begin req_a = 1'b1; adr_a = adr; end
        step();
        for (int i = 1; i <= 10; i++) begin
            step();
            if (sel_b ? valid_b : valid_a) begin
                pulses++;
                if (lat < 0) begin
                    lat  = i;
                    data = sel_b ? read_b : read_a;
                    err  = sel_b ? err_b : err_a;
                end
            end
        end
    endtask

    task automatic drop_req();
        req_a = 1'b0; req_b = 1'b0;
        step();
    endtask

    initial begin
        int          lat, pulses;
        logic [31:0] data;
        logic        err;

        // Reset state
        #2;
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_read",  read_a, 32'd0);
        check("rst_err",   32'(err_a), 32'd0);
        check("rst_state", 32'(u_a.state_q), 32'(RESP_STATE_IDLE));
        step();
        res = 1'b1;
        step();

        load(10'd5, 32'h00A00093);
        load(10'd6, 32'h11111111);
        load(10'd7, 32'h77777777);
        load(10'd8, 32'h88888888);

        // Basic in-range fetch, 2 wait states -> 4-edge latency
        run_req(1'b0, 32'h14, lat, pulses, data, err);
        check("basic_lat",    32'(lat),    32'd4);
        check("basic_pulses", 32'(pulses), 32'd1);
        check("basic_data",   data,        32'h00A00093);
        check("basic_err",    32'(err),    32'd0);
        check("basic_rd0",    read_a,      32'd0);
        // one-cycle low on req, then re-request word 6 with full latency
        drop_req();
        run_req(1'b0, 32'h18, lat, pulses, data, err);
        check("rerq_lat",    32'(lat),    32'd4);
        check("rerq_pulses", 32'(pulses), 32'd1);
        check("rerq_data",   data,        32'h11111111);
        drop_req();

        // Low address bits ignored
        run_req(1'b0, 32'h17, lat, pulses, data, err);
        check("lsb_data", data, 32'h00A00093);
        drop_req();

        // Out of range on the 2-wait instance
        run_req(1'b0, 32'h8000_0014, lat, pulses, data, err);
        check("oor_a_lat",  32'(lat), 32'd4);
        check("oor_a_data", data,     32'd0);
        check("oor_a_err",  32'(err), 32'd1);
        drop_req();

        // Zero wait states, out of range -> 2-edge latency
        run_req(1'b1, 32'h0000_1000, lat, pulses, data, err);
        check("oor_b_lat",    32'(lat),    32'd2);
        check("oor_b_pulses", 32'(pulses), 32'd1);
        check("oor_b_data",   data,        32'd0);
        check("oor_b_err",    32'(err),    32'd1);
        drop_req();
        run_req(1'b1, 32'h14, lat, pulses, data, err);
        check("b_lat",  32'(lat), 32'd2);
        check("b_data", data,     32'h00A00093);
        check("b_err",  32'(err), 32'd0);
        drop_req();

        // Write one cycle before the read edge (lands at E2) -> new value
        req_a = 1'b1; adr_a = 32'h1C;
        step();                                   // E0
        step();                                   // E1
        load_we = 1'b1; load_adr = 10'd7; load_data = 32'hDEADBEEF;
        step();                                   // E2: write
        load_we = 1'b0;
        step();                                   // E3: read
        check("wr_early_pre", 32'(valid_a), 32'd0);
        step();                                   // E4
        check("wr_early_valid", 32'(valid_a), 32'd1);
        check("wr_early_data",  read_a,       32'hDEADBEEF);
        drop_req();

        // Write on the read edge (E3) -> old value
        req_a = 1'b1; adr_a = 32'h20;
        step(); step(); step();                   // E0..E2
        load_we = 1'b1; load_adr = 10'd8; load_data = 32'hDEADBEEF;
        step();                                   // E3: read + write
        load_we = 1'b0;
        step();                                   // E4
        check("wr_same_valid", 32'(valid_a), 32'd1);
        check("wr_same_data",  read_a,       32'h88888888);
        drop_req();
        // the write is visible to a later read
        run_req(1'b0, 32'h20, lat, pulses, data, err);
        check("wr_later_data", data, 32'hDEADBEEF);
        drop_req();

        // Abort in the second WAIT cycle
        req_a = 1'b1; adr_a = 32'h14;
        step();                                   // E0 -> WAIT
        step();                                   // E1, second WAIT cycle
        req_a = 1'b0;
        step();
        check("abort_state", 32'(u_a.state_q), 32'(RESP_STATE_IDLE));
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid_a) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        run_req(1'b0, 32'h18, lat, pulses, data, err);
        check("post_abort_lat",  32'(lat), 32'd4);
        check("post_abort_data", data,     32'h11111111);
        drop_req();

        // Async reset while valid is high clears outputs immediately
        req_a = 1'b1; adr_a = 32'h14;
        for (int i = 0; i < 5; i++) step();       // E0..E4
        check("pre_rst_valid", 32'(valid_a), 32'd1);
        #2 res = 1'b0;
        #1;
        check("rst_mid_valid", 32'(valid_a), 32'd0);
        check("rst_mid_read",  read_a,       32'd0);
        step();
        res = 1'b1;
        drop_req();

        // Async reset mid-WAIT, released with req held -> fresh access
        req_a = 1'b1; adr_a = 32'h14;
        step(); step();                           // in WAIT
        #2 res = 1'b0;
        #1;
        check("rstw_state", 32'(u_a.state_q), 32'(RESP_STATE_IDLE));
        check("rstw_valid", 32'(valid_a), 32'd0);
        #1 res = 1'b1;
        // req still high: the next edge samples it as a new request
        run_req(1'b0, 32'h14, lat, pulses, data, err);
        check("rstw_lat",    32'(lat),    32'd4);
        check("rstw_pulses", 32'(pulses), 32'd1);
        check("rstw_data",   data,        32'h00A00093);
        drop_req();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
